// File: rtl/spi_pixel_receiver.sv
// Receives MSB-first nibbles over the 4-line SPI pixel link and emits full pixels with raster position.
// Optional frame alignment check against the sender's final-pixel flag: define SPI_RECV_FRAME_CHECK_EN.
module spi_pixel_receiver #(
   parameter int DATA_WIDTH = 8,
   parameter int LINES      = 4,
   parameter int H_ACTIVE   = 1280,
   parameter int V_ACTIVE   = 720
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic [LINES-1:0]      chip_data_in,
   input  logic                  chip_clk_in,
   input  logic                  chip_sel_in,
   input  logic                  final_pixel_in,
   input  logic                  clear_err_in,
   output logic [DATA_WIDTH-1:0] pixel_out,
   output logic                  pixel_valid_out,
   output logic [10:0]           hcount_out,
   output logic [9:0]            vcount_out,
   output logic                  frame_done_out,
   output logic                  short_err_out,
   output logic                  long_err_out,
   output logic                  frame_err_out
);

   localparam int NIBBLES = DATA_WIDTH / LINES;
   localparam int BEAT_W  = $clog2(NIBBLES + 1);
   localparam logic [BEAT_W-1:0] BEAT_FULL = BEAT_W'(NIBBLES);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NIBBLES - 1);
   localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
   localparam logic [BEAT_W-1:0] BEAT_ZERO = BEAT_W'(0);
   localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
   localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RECV = 1'b1} state_t;

   state_t state_r, state_next_s;
   logic clk_s1_r, clk_s2_r, clk_d_r;
   logic cs_s1_r, cs_s2_r, cs_d_r;
   logic fin_s1_r, fin_s2_r, fin_lat_r;
   logic [LINES-1:0] data_s1_r, data_s2_r;
   logic dclk_rise_s, cs_fall_s, cs_rise_s;
   logic start_s, capture_s, long_s, short_s;
   logic [BEAT_W-1:0] beat_r;
   logic [DATA_WIDTH-1:0] shift_r, pixel_r;
   logic emit_pend_r;
   logic [10:0] hcount_r, h_next_s, hcount_out_r;
   logic [9:0]  vcount_r, v_next_s, vcount_out_r;
   logic at_last_s, force_zero_s, frame_end_s, frame_mis_s;
   logic valid_r, done_r, short_err_r, long_err_r, frame_err_r;

   // Two-flop synchronizers plus one edge-detect stage; data and flag follow the DCLK path.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         clk_s1_r  <= 1'b0;
         clk_s2_r  <= 1'b0;
         clk_d_r   <= 1'b0;
         cs_s1_r   <= 1'b1;
         cs_s2_r   <= 1'b1;
         cs_d_r    <= 1'b1;
         fin_s1_r  <= 1'b0;
         fin_s2_r  <= 1'b0;
         data_s1_r <= '0;
         data_s2_r <= '0;
      end else begin
         clk_s1_r  <= chip_clk_in;
         clk_s2_r  <= clk_s1_r;
         clk_d_r   <= clk_s2_r;
         cs_s1_r   <= chip_sel_in;
         cs_s2_r   <= cs_s1_r;
         cs_d_r    <= cs_s2_r;
         fin_s1_r  <= final_pixel_in;
         fin_s2_r  <= fin_s1_r;
         data_s1_r <= chip_data_in;
         data_s2_r <= data_s1_r;
      end
   end

   assign dclk_rise_s = clk_s2_r & ~clk_d_r;
   assign cs_fall_s   = ~cs_s2_r & cs_d_r;
   assign cs_rise_s   = cs_s2_r & ~cs_d_r;

   // FSM state register.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: if (cs_fall_s) state_next_s = ST_RECV; else state_next_s = ST_IDLE;
         ST_RECV: if (cs_rise_s) state_next_s = ST_IDLE; else state_next_s = ST_RECV;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // FSM outputs: per-cycle beat and error controls.
   always_comb begin
      start_s   = 1'b0;
      capture_s = 1'b0;
      long_s    = 1'b0;
      short_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (cs_fall_s) start_s = 1'b1; else start_s = 1'b0;
         end
         ST_RECV: begin
            if (cs_fall_s) begin
               start_s = 1'b1;
               short_s = (beat_r != BEAT_ZERO);
            end else if (cs_rise_s) begin
               short_s = (beat_r != BEAT_ZERO) && (beat_r < BEAT_FULL);
            end else if (dclk_rise_s) begin
               if (beat_r == BEAT_FULL) long_s = 1'b1; else capture_s = 1'b1;
            end else begin
               capture_s = 1'b0;
            end
         end
         default: start_s = 1'b0;
      endcase
   end

   // Beat counter, nibble shift register and final-flag latch.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         beat_r      <= BEAT_ZERO;
         shift_r     <= '0;
         fin_lat_r   <= 1'b0;
         emit_pend_r <= 1'b0;
      end else begin
         emit_pend_r <= capture_s && (beat_r == BEAT_LAST);
         if (start_s) begin
            beat_r <= BEAT_ZERO;
         end else if (capture_s) begin
            beat_r  <= beat_r + BEAT_ONE;
            shift_r <= {shift_r[DATA_WIDTH-LINES-1:0], data_s2_r};
            if (beat_r == BEAT_ZERO) fin_lat_r <= fin_s2_r;
         end
      end
   end

   // Next raster position and frame-end classification of the pixel being emitted.
   always_comb begin
      at_last_s = (hcount_r == H_LAST) && (vcount_r == V_LAST);
`ifdef SPI_RECV_FRAME_CHECK_EN
      force_zero_s = fin_lat_r & ~at_last_s;
      frame_end_s  = fin_lat_r | at_last_s;
      frame_mis_s  = fin_lat_r ^ at_last_s;
`else
      force_zero_s = 1'b0;
      frame_end_s  = at_last_s;
      frame_mis_s  = 1'b0;
`endif
      h_next_s = hcount_r;
      v_next_s = vcount_r;
      if (force_zero_s) begin
         h_next_s = 11'd0;
         v_next_s = 10'd0;
      end else if (hcount_r == H_LAST) begin
         h_next_s = 11'd0;
         v_next_s = (vcount_r == V_LAST) ? 10'd0 : vcount_r + 10'd1;
      end else begin
         h_next_s = hcount_r + 11'd1;
      end
   end

`ifndef SPI_RECV_FRAME_CHECK_EN
   // The latched final flag is not consulted without frame checking.
   logic unused_fin_s;
   assign unused_fin_s = fin_lat_r;
`endif

   // Registered pixel outputs, position counters and sticky error flags.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         pixel_r      <= '0;
         valid_r      <= 1'b0;
         done_r       <= 1'b0;
         hcount_r     <= 11'd0;
         vcount_r     <= 10'd0;
         hcount_out_r <= 11'd0;
         vcount_out_r <= 10'd0;
         short_err_r  <= 1'b0;
         long_err_r   <= 1'b0;
         frame_err_r  <= 1'b0;
      end else begin
         valid_r <= emit_pend_r;
         done_r  <= emit_pend_r & frame_end_s;
         if (emit_pend_r) begin
            pixel_r      <= shift_r;
            hcount_out_r <= hcount_r;
            vcount_out_r <= vcount_r;
            hcount_r     <= h_next_s;
            vcount_r     <= v_next_s;
         end
         if (short_s) short_err_r <= 1'b1;
         else if (clear_err_in) short_err_r <= 1'b0;
         if (long_s) long_err_r <= 1'b1;
         else if (clear_err_in) long_err_r <= 1'b0;
         if (emit_pend_r && frame_mis_s) frame_err_r <= 1'b1;
         else if (clear_err_in) frame_err_r <= 1'b0;
      end
   end

   assign pixel_out       = pixel_r;
   assign pixel_valid_out = valid_r;
   assign hcount_out      = hcount_out_r;
   assign vcount_out      = vcount_out_r;
   assign frame_done_out  = done_r;
   assign short_err_out   = short_err_r;
   assign long_err_out    = long_err_r;
   assign frame_err_out   = frame_err_r;

endmodule

// File: tb/tb_spi_pixel_receiver.sv
// Directed bench for spi_pixel_receiver on a reduced 8x4 raster; expected pixels go through a scoreboard queue.
module tb_spi_pixel_receiver;

   localparam int HA = 8;
   localparam int VA = 4;
   localparam int HP = 4;

   logic clk = 1'b0;
   logic rst_n, dclk, cs, fin_pin, clr;
   logic [3:0] data;
   logic [7:0] pixel;
   logic pixel_valid, frame_done, short_err, long_err, frame_err;
   logic [10:0] hcount;
   logic [9:0] vcount;

   int n_assert = 0;
   int n_fail = 0;
   logic [29:0] exp_q[$];
   logic [10:0] eh;
   logic [9:0] ev;
   logic exp_ferr;

   always #5 clk = ~clk;

   spi_pixel_receiver #(.DATA_WIDTH(8), .LINES(4), .H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .chip_data_in(data), .chip_clk_in(dclk),
      .chip_sel_in(cs), .final_pixel_in(fin_pin), .clear_err_in(clr),
      .pixel_out(pixel), .pixel_valid_out(pixel_valid), .hcount_out(hcount),
      .vcount_out(vcount), .frame_done_out(frame_done), .short_err_out(short_err),
      .long_err_out(long_err), .frame_err_out(frame_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Spec-level position model: push the expected tuple and advance the raster.
   task automatic push_px(input logic [7:0] px, input logic fin);
      logic at_last, done, force0;
      at_last = (eh == 11'(HA - 1)) && (ev == 10'(VA - 1));
      force0 = 1'b0;
`ifdef SPI_RECV_FRAME_CHECK_EN
      done = fin | at_last;
      if (fin != at_last) exp_ferr = 1'b1;
      force0 = fin & ~at_last;
`else
      done = at_last | (fin & 1'b0);
`endif
      exp_q.push_back({px, eh, ev, done});
      if (force0) begin
         eh = 11'd0; ev = 10'd0;
      end else if (eh == 11'(HA - 1)) begin
         eh = 11'd0;
         ev = (ev == 10'(VA - 1)) ? 10'd0 : ev + 10'd1;
      end else begin
         eh = eh + 11'd1;
      end
   endtask

   task automatic xfer(input logic [11:0] nibs, input int n, input logic fin, input int hp, input bit chk);
      @(negedge clk);
      cs = 1'b0;
      repeat (hp) @(negedge clk);
      for (int i = 0; i < n; i++) begin
         data = nibs[(11 - 4 * i) -: 4];
         fin_pin = (i == 0) ? fin : 1'b0;
         repeat (hp) @(negedge clk);
         dclk = 1'b1;
         if (chk && i == n - 1) begin
            repeat (3) @(negedge clk);
            check("latency_pre", pixel_valid, 1'b0);
            @(negedge clk);
            check("latency_hit", pixel_valid, 1'b1);
            @(negedge clk);
            check("strobe_one_cycle", pixel_valid, 1'b0);
            repeat (hp - 5) @(negedge clk);
         end else begin
            repeat (hp) @(negedge clk);
         end
         dclk = 1'b0;
      end
      fin_pin = 1'b0;
      repeat (hp) @(negedge clk);
      cs = 1'b1;
      repeat (hp) @(negedge clk);
   endtask

   task automatic send_px(input logic [7:0] px, input logic fin);
      push_px(px, fin);
      xfer({px, 4'h0}, 2, fin, HP, 1'b0);
   endtask

   task automatic drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("scoreboard_drained", exp_q.size(), 0);
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic hard_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      eh = 11'd0; ev = 10'd0; exp_ferr = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // Output monitor: compare every strobe against the head of the scoreboard.
   initial begin
      logic prev_v;
      logic [29:0] e;
      prev_v = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && pixel_valid === 1'b1) begin
            check("no_back_to_back", prev_v, 1'b0);
            check("pixel_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("pixel_pos_done", {pixel, hcount, vcount, frame_done}, e);
            end
         end
         if (frame_done === 1'b1) check("done_with_valid", pixel_valid, 1'b1);
         prev_v = pixel_valid;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; dclk = 1'b0; cs = 1'b1; fin_pin = 1'b0; clr = 1'b0; data = 4'h0;
      eh = 11'd0; ev = 10'd0; exp_ferr = 1'b0;
      #1;
      check("reset_outputs", {pixel, pixel_valid, hcount, vcount, frame_done, short_err, long_err, frame_err}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // First pixel 0xA5 at (0,0), slow DCLK, latency measured inline.
      push_px(8'hA5, 1'b0);
      xfer(12'hA50, 2, 1'b0, 50, 1'b1);
      drain();

      // Reset between beats 1 and 2.
      @(negedge clk);
      cs = 1'b0;
      repeat (HP) @(negedge clk);
      data = 4'h3;
      repeat (HP) @(negedge clk);
      dclk = 1'b1;
      repeat (HP) @(negedge clk);
      dclk = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset_outputs", {pixel, pixel_valid, hcount, vcount, frame_done, short_err, long_err, frame_err}, 32'd0);
      @(negedge clk);
      cs = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      eh = 11'd0; ev = 10'd0; exp_ferr = 1'b0;
      repeat (HP) @(negedge clk);

      // Full frame, value = index, final flag on the last pixel.
      for (int i = 0; i < HA * VA; i++) send_px(8'(i), (i == HA * VA - 1));
      drain();
      check("frame_short_err", short_err, 1'b0);
      check("frame_long_err", long_err, 1'b0);
      check("frame_frame_err", frame_err, 1'b0);

      // Short transaction: one beat only.
      xfer(12'h700, 1, 1'b0, HP, 1'b0);
      check("short_err_set", short_err, 1'b1);
      send_px(8'h3C, 1'b0);
      drain();
      pulse_clear();
      check("short_err_cleared", short_err, 1'b0);

      // Long transaction: three beats, third discarded.
      push_px(8'h12, 1'b0);
      xfer(12'h12F, 3, 1'b0, HP, 1'b0);
      drain();
      check("long_err_set", long_err, 1'b1);
      check("long_no_short", short_err, 1'b0);
      pulse_clear();
      check("long_err_cleared", long_err, 1'b0);

      // Final flag early on pixel index 10 (checked only when frame checking is built in).
      hard_reset();
      for (int i = 0; i <= 10; i++) send_px(8'h40 + 8'(i), (i == 10));
      send_px(8'h77, 1'b0);
      drain();
      check("frame_err_flag", frame_err, exp_ferr);
      check("fc_short_err", short_err, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_pixel_receiver.md
# spi_pixel_receiver

Controller-side receiver for the 4-line SPI pixel link driven by the peripheral FPGA. It synchronizes the incoming DCLK, CS, data lines and final-pixel flag into the `clk_in` domain. It samples one nibble per DCLK rising edge while CS is low and reassembles MSB-first nibbles into full pixels. Each pixel is emitted with its raster position, and the block optionally checks frame alignment against the sender's final-pixel flag. It sits between the SPI pins and the main FPGA's frame buffer write port.

## Interface
Parameters:
- `DATA_WIDTH`, 8: pixel width; must be a multiple of `LINES`.
- `LINES`, 4: SPI data lines; beats per pixel `NIBBLES = DATA_WIDTH/LINES`.
- `H_ACTIVE`, 1280: pixels per line.
- `V_ACTIVE`, 720: lines per frame.

Ports (one clock `clk_in`; reset `rst_n_in` is asynchronous, active-low):
- `clk_in` in 1: system clock, 100 MHz.
- `rst_n_in` in 1: asynchronous active-low reset.
- `chip_data_in` in `LINES`: CIPO data from the peripheral.
- `chip_clk_in` in 1: DCLK from the peripheral.
- `chip_sel_in` in 1: CS, active-low.
- `final_pixel_in` in 1: sender's last-pixel-of-frame flag.
- `clear_err_in` in 1: clears sticky error flags.
- `pixel_out` out `DATA_WIDTH`: reassembled pixel.
- `pixel_valid_out` out 1: one-cycle strobe; `pixel_out`, `hcount_out` and `vcount_out` are valid in that cycle.
- `hcount_out` out 11: column of `pixel_out`.
- `vcount_out` out 10: row of `pixel_out`.
- `frame_done_out` out 1: one-cycle strobe with the last pixel of a frame.
- `short_err_out` out 1: sticky; a transaction ended before receiving `NIBBLES` beats.
- `long_err_out` out 1: sticky; a transaction carried more than `NIBBLES` beats.
- `frame_err_out` out 1: sticky; frame position mismatch (only when checking is compiled in).

## Operation
- **Synchronizers:** `chip_clk_in`, `chip_sel_in`, `chip_data_in` and `final_pixel_in` each pass through a 2-flop synchronizer. The data path is delayed identically to the clock path.
- **Edge detection:** a registered copy of the synchronized DCLK gives a rise strobe. A registered copy of the synchronized CS gives fall (start) and rise (end) strobes.
- **States:**
  - IDLE: CS high. DCLK rises are ignored.
  - RECV: entered on CS fall; beat counter cleared to 0.
  - Return to IDLE on CS rise.
- **Beat capture in RECV**, on each DCLK rise:
  - If `beat < NIBBLES`: shift the synchronized data into the low bits of the shift register (MSB first) and increment `beat`.
  - If `beat == NIBBLES`: discard the beat and set `long_err_out`.
  - `final_pixel_in` is latched on beat 0, because the sender clears it after the first beat.
- **Pixel emit:**
  - When `beat` reaches `NIBBLES`, register `pixel_out`, the current position counters and `pixel_valid_out`.
  - The position counters then advance. `hcount` wraps from `H_ACTIVE-1` to 0 and increments `vcount`; `vcount` wraps from `V_ACTIVE-1` to 0.
- **Short transaction:** CS rise with `0 < beat < NIBBLES` discards the partial pixel, sets `short_err_out` and leaves the counters unchanged. CS rise with `beat == 0` is silent.
- **Start without end:** a CS fall while already in RECV (CS glitch) restarts the beat count. Partial data is discarded and `short_err_out` is set if `beat > 0`.
- **Sticky errors:** cleared by `clear_err_in`. If a set and a clear occur in the same cycle, the set wins.
- **Reset values:** all outputs 0, state IDLE, counters (0,0). Synchronizer flops reset CS to 1 and everything else to 0. Reset mid-transaction discards the partial pixel.

## Timing
- Required link timing: DCLK high and low phases each ≥ 4 `clk_in` cycles, and data stable for ≥ 4 cycles around the DCLK rise.
- Latency: `pixel_valid_out` goes high exactly 3 `clk_in` cycles after the first `clk_in` edge that captures the final DCLK rise high on the pin. This is 2 synchronizer cycles plus 1 output register.
- `frame_done_out` is coincident with `pixel_valid_out`.
- `pixel_valid_out` is never high on consecutive cycles.

## Configuration
- `SPI_RECV_FRAME_CHECK_EN` defined:
  - A pixel emitted with latched final flag = 1 asserts `frame_done_out`.
  - If its position is not (`H_ACTIVE-1`, `V_ACTIVE-1`), `frame_err_out` is set and the counters are forced to (0,0) for the next pixel.
  - A pixel at (`H_ACTIVE-1`, `V_ACTIVE-1`) with flag = 0 sets `frame_err_out`, asserts `frame_done_out` and wraps normally.
- `SPI_RECV_FRAME_CHECK_EN` undefined:
  - `final_pixel_in` is ignored and the counters free-run.
  - `frame_done_out` pulses on the pixel at (`H_ACTIVE-1`, `V_ACTIVE-1`).
  - `frame_err_out` is tied to 0.

## Test plan
- Reset, then one transaction with nibbles 0xA then 0x5, DCLK half-period 50 cycles -> `pixel_out`=0xA5, position (0,0), valid 3 cycles after the second DCLK rise, one-cycle strobe.
- 1280×720 back-to-back pixels, pixel value = index[7:0], final flag on the last -> every `pixel_out`/position matches; a single `frame_done_out` at (1279,719); next pixel at (0,0); no errors.
- CS deasserted after 1 beat -> no valid strobe, `short_err_out`=1, the next full pixel is still at (0,0); `clear_err_in` returns `short_err_out` to 0.
- 3 DCLK rises within one CS window with nibbles 0x1, 0x2, 0xF -> `pixel_out`=0x12, `long_err_out`=1.
- With `SPI_RECV_FRAME_CHECK_EN`: final flag on pixel index 10 -> `frame_err_out`=1, `frame_done_out` pulse, next pixel at (0,0).
- `rst_n_in` low between beats 1 and 2 -> all outputs 0 immediately; after release the next complete transaction is emitted at (0,0) with no error.
